// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants for the control decoder and the program loader:
// opcodes, R-type function codes, the loader's request-kind encoding and field packers.
package mips_isa_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;

    localparam logic [5:0] FUNC_ADD = 6'h20;
    localparam logic [5:0] FUNC_SUB = 6'h22;
    localparam logic [5:0] FUNC_AND = 6'h24;
    localparam logic [5:0] FUNC_OR  = 6'h25;

    typedef enum logic [2:0] {
        KIND_ADD     = 3'd0,
        KIND_SUB     = 3'd1,
        KIND_AND     = 3'd2,
        KIND_OR      = 3'd3,
        KIND_LW      = 3'd4,
        KIND_SW      = 3'd5,
        KIND_BEQ     = 3'd6,
        KIND_INVALID = 3'd7
    } kind_t;

    function automatic logic [31:0] pack_rtype(input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [5:0] func);
        return {OP_RTYPE, rs, rt, rd, 5'd0, func};
    endfunction

    function automatic logic [31:0] pack_itype(input logic [5:0] op, input logic [4:0] rs,
                                               input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational instruction packer: turns one symbolic request into a 32-bit MIPS
// word. BEQ targets are absolute word addresses, converted relative to pointer+1.
module mips_instr_pack
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [2:0]        kind,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic [ADDR_W-1:0] pointer,
    output logic [31:0]       word,
    output logic              valid_kind
);

    localparam logic [15:0] ADDR_MASK = 16'((32'd1 << ADDR_W) - 32'd1);

    logic [15:0] target;
    logic [15:0] next_pc;
    logic [15:0] beq_offset;

    // Offset wraps mod 2^16; out-of-range targets are deliberately not flagged.
    assign target     = imm & ADDR_MASK;
    assign next_pc    = 16'(pointer) + 16'd1;
    assign beq_offset = target - next_pc;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned; otherwise a latch is inferred.
        word       = '0;
        valid_kind = 1'b1;
        case (kind_t'(kind))
            KIND_ADD: word = pack_rtype(rs, rt, rd, FUNC_ADD);
            KIND_SUB: word = pack_rtype(rs, rt, rd, FUNC_SUB);
            KIND_AND: word = pack_rtype(rs, rt, rd, FUNC_AND);
            KIND_OR:  word = pack_rtype(rs, rt, rd, FUNC_OR);
            KIND_LW:  word = pack_itype(OP_LW, rs, rt, imm);
            KIND_SW:  word = pack_itype(OP_SW, rs, rt, imm);
            KIND_BEQ: word = pack_itype(OP_BEQ, rs, rt, beq_offset);
            default:  valid_kind = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: accepts symbolic instruction requests, packs them into MIPS words
// and writes them sequentially into instruction memory with back-pressure.
module mips_instr_encoder
    import mips_isa_pkg::*;
#(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic [ADDR_W:0]   instr_count,
    output logic              err,
    output logic              full
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCEPT,
        ST_WRITE,
        ST_FULL
    } state_t;

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE = 1;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pointer;
    logic [31:0]       packed_word;
    logic              valid_kind;
    logic              accept;
    logic              reject;
    logic              commit;

    mips_instr_pack #(
        .ADDR_W (ADDR_W)
    ) u_pack (
        .kind       (in_kind),
        .rs         (in_rs),
        .rt         (in_rt),
        .rd         (in_rd),
        .imm        (in_imm),
        .pointer    (pointer),
        .word       (packed_word),
        .valid_kind (valid_kind)
    );

    // Ready drops while start/rst are asserted so a restart never silently swallows a request.
    assign in_ready = (state == ST_ACCEPT) && !start && !rst;
    assign accept   = in_ready && in_valid && valid_kind;
    assign reject   = in_ready && in_valid && !valid_kind;
    assign commit   = (state == ST_WRITE) && mem_ready;
    assign mem_we   = (state == ST_WRITE);
    assign full     = (state == ST_FULL);

    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (start) begin
            next_state = ST_ACCEPT;
        end else begin
            case (state)
                ST_ACCEPT: if (accept) next_state = ST_WRITE;
                ST_WRITE: begin
                    if (mem_ready) begin
                        next_state = (mem_addr == '1) ? ST_FULL : ST_ACCEPT;
                    end
                end
                ST_IDLE, ST_FULL: next_state = state;
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // mem_addr keeps the last written address after commit; pointer is the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            pointer     <= BASE_ADDR;
            instr_count <= '0;
            err         <= 1'b0;
            mem_addr    <= BASE_ADDR;
            mem_wdata   <= '0;
        end else if (start) begin
            pointer     <= BASE_ADDR;
            instr_count <= '0;
            err         <= 1'b0;
            mem_addr    <= BASE_ADDR;
        end else begin
            if (accept) begin
                mem_addr  <= pointer;
                mem_wdata <= packed_word;
            end
            if (reject) begin
                err <= 1'b1;
            end
            if (commit) begin
                pointer     <= pointer + PTR_ONE;
                instr_count <= instr_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Bench for mips_instr_encoder: two instances (8-bit and 2-bit address space) share
// stimulus and are checked every cycle against a behavioural model of the loader.
module tb_mips_instr_encoder;

    localparam int AW_A = 8;
    localparam int AW_B = 2;
    localparam int MS_IDLE = 0, MS_ACC = 1, MS_WR = 2, MS_FULL = 3;

    logic              clk;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [2:0]        in_kind;
    logic [4:0]        in_rs, in_rt, in_rd;
    logic [15:0]       in_imm;
    logic              mem_ready_a, mem_ready_b;

    logic              in_ready_a, mem_we_a, err_a, full_a;
    logic [AW_A-1:0]   mem_addr_a;
    logic [31:0]       mem_wdata_a;
    logic [AW_A:0]     instr_count_a;

    logic              in_ready_b, mem_we_b, err_b, full_b;
    logic [AW_B-1:0]   mem_addr_b;
    logic [31:0]       mem_wdata_b;
    logic [AW_B:0]     instr_count_b;

    int checks = 0;
    int errors = 0;
    logic cmp_en = 1'b0;

    // Model state per instance: 0 = 8-bit instance, 1 = 2-bit instance.
    int          m_state[2];
    int          m_ptr[2];
    int          m_cnt[2];
    int          m_err[2];
    int          m_addr[2];
    logic [31:0] m_wdata[2];
    int          aw[2];

    mips_instr_encoder #(.ADDR_W(AW_A), .BASE_ADDR(8'd0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_ready(mem_ready_a), .instr_count(instr_count_a), .err(err_a), .full(full_a)
    );

    mips_instr_encoder #(.ADDR_W(AW_B), .BASE_ADDR(2'd0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_ready(mem_ready_b), .instr_count(instr_count_b), .err(err_b), .full(full_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction word straight from the ISA tables, using plain integer arithmetic.
    function automatic logic [31:0] model_encode(input int kind, input int rs, input int rt,
                                                 input int rd, input int imm, input int ptr,
                                                 input int w);
        longint word;
        int     funct, op, field, off;
        if (kind <= 3) begin
            funct = (kind == 0) ? 32 : (kind == 1) ? 34 : (kind == 2) ? 36 : 37;
            word  = (longint'(rs) << 21) + (longint'(rt) << 16) + (longint'(rd) << 11)
                  + longint'(funct);
        end else begin
            op    = (kind == 4) ? 35 : (kind == 5) ? 43 : 4;
            field = imm;
            if (kind == 6) begin
                off = (imm % (1 << w)) - (ptr + 1);
                if (off < 0) off += 65536;
                field = off;
            end
            word = (longint'(op) << 26) + (longint'(rs) << 21) + (longint'(rt) << 16)
                 + longint'(field);
        end
        return word[31:0];
    endfunction

    initial begin
        aw[0] = AW_A;
        aw[1] = AW_B;
        for (int i = 0; i < 2; i++) begin
            m_state[i] = MS_IDLE; m_ptr[i] = 0; m_cnt[i] = 0;
            m_err[i] = 0; m_addr[i] = 0; m_wdata[i] = '0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_state[i] <= MS_IDLE; m_ptr[i] <= 0; m_cnt[i] <= 0;
                m_err[i] <= 0; m_addr[i] <= 0; m_wdata[i] <= '0;
            end else if (start) begin
                m_state[i] <= MS_ACC; m_ptr[i] <= 0; m_cnt[i] <= 0;
                m_err[i] <= 0; m_addr[i] <= 0;
            end else if (m_state[i] == MS_ACC && in_valid) begin
                if (in_kind == 3'd7) begin
                    m_err[i] <= 1;
                end else begin
                    m_wdata[i] <= model_encode(int'(in_kind), int'(in_rs), int'(in_rt),
                                               int'(in_rd), int'(in_imm), m_ptr[i], aw[i]);
                    m_addr[i]  <= m_ptr[i];
                    m_state[i] <= MS_WR;
                end
            end else if (m_state[i] == MS_WR && ((i == 0) ? mem_ready_a : mem_ready_b)) begin
                m_cnt[i]   <= m_cnt[i] + 1;
                m_ptr[i]   <= (m_ptr[i] + 1) % (1 << aw[i]);
                m_state[i] <= (m_addr[i] == (1 << aw[i]) - 1) ? MS_FULL : MS_ACC;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("a_in_ready", 32'(in_ready_a), 32'(!rst && !start && m_state[0] == MS_ACC));
            check("a_mem_we", 32'(mem_we_a), 32'(m_state[0] == MS_WR));
            check("a_mem_addr", 32'(mem_addr_a), 32'(m_addr[0]));
            check("a_mem_wdata", mem_wdata_a, m_wdata[0]);
            check("a_instr_count", 32'(instr_count_a), 32'(m_cnt[0]));
            check("a_err", 32'(err_a), 32'(m_err[0]));
            check("a_full", 32'(full_a), 32'(m_state[0] == MS_FULL));
            check("b_in_ready", 32'(in_ready_b), 32'(!rst && !start && m_state[1] == MS_ACC));
            check("b_mem_we", 32'(mem_we_b), 32'(m_state[1] == MS_WR));
            check("b_mem_addr", 32'(mem_addr_b), 32'(m_addr[1]));
            check("b_mem_wdata", mem_wdata_b, m_wdata[1]);
            check("b_instr_count", 32'(instr_count_b), 32'(m_cnt[1]));
            check("b_err", 32'(err_b), 32'(m_err[1]));
            check("b_full", 32'(full_b), 32'(m_state[1] == MS_FULL));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present a request and hold it until instance A takes it (bounded wait).
    task automatic send(input int kind, input int rs, input int rt, input int rd, input int imm);
        int budget;
        in_valid = 1'b1;
        in_kind  = 3'(kind);
        in_rs    = 5'(rs);
        in_rt    = 5'(rt);
        in_rd    = 5'(rd);
        in_imm   = 16'(imm);
        budget   = 0;
        @(negedge clk);
        while (!in_ready_a && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check("send_accepted", 32'(in_ready_a), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for instance A's write strobe, check it, then step past the next edge.
    task automatic expect_write(input string name, input int addr, input logic [31:0] word);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!mem_we_a && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        check({name, "_we"}, 32'(mem_we_a), 32'd1);
        check({name, "_addr"}, 32'(mem_addr_a), 32'(addr));
        check({name, "_wdata"}, mem_wdata_a, word);
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_kind = '0;
        in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0;
        mem_ready_a = 1'b1; mem_ready_b = 1'b1;

        check("pin_add", model_encode(0, 1, 2, 3, 0, 0, 8), 32'h00221820);
        check("pin_lw", model_encode(4, 4, 5, 0, 16, 0, 8), 32'h8C850010);
        check("pin_sw", model_encode(5, 4, 5, 0, 16, 1, 8), 32'hAC850010);
        check("pin_beq", model_encode(6, 1, 2, 0, 2, 5, 8), 32'h1022FFFC);
        check("pin_beq_wrap", model_encode(6, 0, 0, 0, 0, 255, 8), 32'h1000FF00);
        check("pin_sub", model_encode(1, 3, 4, 5, 0, 0, 8), 32'h00642822);

        tick();
        cmp_en = 1'b1;
        tick();
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready_a), 32'd0);
        check("rst_mem_we", 32'(mem_we_a), 32'd0);
        check("rst_mem_addr", 32'(mem_addr_a), 32'd0);
        check("rst_mem_wdata", mem_wdata_a, 32'd0);
        check("rst_count", 32'(instr_count_a), 32'd0);
        check("rst_err_full", {30'd0, err_a, full_a}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("idle_in_ready", 32'(in_ready_a), 32'd0);
        pulse_start();

        send(0, 1, 2, 3, 0);
        expect_write("add", 0, 32'h00221820);
        @(negedge clk);
        check("add_we_one_cycle", 32'(mem_we_a), 32'd0);
        check("add_count", 32'(instr_count_a), 32'd1);
        tick();

        send(4, 4, 5, 0, 16'h0010);
        expect_write("lw", 1, 32'h8C850010);
        send(5, 4, 5, 0, 16'h0010);
        expect_write("sw", 2, 32'hAC850010);
        send(2, 7, 8, 9, 0);
        expect_write("and", 3, model_encode(2, 7, 8, 9, 0, 3, 8));
        send(3, 10, 11, 12, 0);
        expect_write("or", 4, model_encode(3, 10, 11, 12, 0, 4, 8));
        send(6, 1, 2, 0, 2);
        expect_write("beq", 5, 32'h1022FFFC);

        mem_ready_a = 1'b0;
        send(1, 3, 4, 5, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_we", 32'(mem_we_a), 32'd1);
            check("stall_addr", 32'(mem_addr_a), 32'd6);
            check("stall_wdata", mem_wdata_a, 32'h00642822);
            check("stall_in_ready", 32'(in_ready_a), 32'd0);
            check("stall_count", 32'(instr_count_a), 32'd6);
            tick();
        end
        mem_ready_a = 1'b1;
        expect_write("sub", 6, 32'h00642822);
        @(negedge clk);
        check("sub_count", 32'(instr_count_a), 32'd7);
        tick();

        in_valid = 1'b1; in_kind = 3'd7;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("bad_err", 32'(err_a), 32'd1);
        check("bad_no_we", 32'(mem_we_a), 32'd0);
        check("bad_in_ready", 32'(in_ready_a), 32'd1);
        tick();
        send(0, 1, 2, 3, 0);
        expect_write("after_bad", 7, 32'h00221820);
        @(negedge clk);
        check("err_sticky", 32'(err_a), 32'd1);
        tick();
        pulse_start();
        @(negedge clk);
        check("start_clears_err", 32'(err_a), 32'd0);
        check("start_clears_count", 32'(instr_count_a), 32'd0);
        tick();

        for (int k = 0; k < 4; k++) begin
            send(0, k, k + 1, k + 2, 0);
            expect_write("fill", k, model_encode(0, k, k + 1, k + 2, 0, k, 8));
        end
        @(negedge clk);
        check("b_full_set", 32'(full_b), 32'd1);
        check("b_full_in_ready", 32'(in_ready_b), 32'd0);
        check("b_full_count", 32'(instr_count_b), 32'd4);
        tick();
        pulse_start();
        @(negedge clk);
        check("b_restart_full", 32'(full_b), 32'd0);
        check("b_restart_count", 32'(instr_count_b), 32'd0);
        check("b_restart_addr", 32'(mem_addr_b), 32'd0);
        tick();

        mem_ready_a = 1'b0; mem_ready_b = 1'b0;
        send(4, 9, 10, 0, 16'h1234);
        @(negedge clk);
        check("b_pending_we", 32'(mem_we_b), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("b_rst_mid_write_we", 32'(mem_we_b), 32'd0);
        check("a_rst_mid_write_we", 32'(mem_we_a), 32'd0);
        check("b_rst_mid_write_addr", 32'(mem_addr_b), 32'd0);
        tick();
        mem_ready_a = 1'b1; mem_ready_b = 1'b1;
        pulse_start();

        for (int cyc = 0; cyc < 4000; cyc++) begin
            rst         = ($urandom_range(0, 499) == 0);
            start       = ($urandom_range(0, 149) == 0);
            in_valid    = ($urandom_range(0, 9) < 7);
            in_kind     = 3'($urandom_range(0, 7));
            in_rs       = 5'($urandom);
            in_rt       = 5'($urandom);
            in_rd       = 5'($urandom);
            in_imm      = 16'($urandom);
            mem_ready_a = ($urandom_range(0, 9) < 6);
            mem_ready_b = ($urandom_range(0, 9) < 6);
            tick();
        end
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        tick();
        @(negedge clk);
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
